// File: rtl/halton_pair_buffer.sv
// Credit-controlled FWFT FIFO that buffers (base-2, base-3) Halton point pairs from a multi-base generator.
// Optional macro HALTON_PAIR_BUFFER_STATS_EN adds the pt_count output (dequeued point counter).
module halton_pair_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       flush,
    output logic                       gen_pop,
    input  logic [WIDTH-1:0]           gen_x,
    input  logic [WIDTH-1:0]           gen_y,
    input  logic                       gen_valid,
    output logic [WIDTH-1:0]           out_x,
    output logic [WIDTH-1:0]           out_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       busy
`ifdef HALTON_PAIR_BUFFER_STATS_EN
    ,
    output logic [31:0]                pt_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW:0]   DEPTH_S  = (LW+1)'(DEPTH);
    localparam logic [LW-1:0] CNT_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_next_s;
    logic [LW-1:0]   outstanding_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic            overflow_r;
    logic [WIDTH-1:0] mem_x_r [DEPTH];
    logic [WIDTH-1:0] mem_y_r [DEPTH];

    logic            out_valid_s;
    logic            deq_s;
    logic            enq_s;
    logic            drop_s;
    logic            full_s;
    logic            clear_s;

    // Datapath handshake decode; the FIFO is blocked from draining while flushing.
    always_comb begin
        out_valid_s = (level_r != {LW{1'b0}}) && (state_r != S_FLUSH);
        deq_s       = out_valid_s && out_ready;
        full_s      = (level_r == DEPTH_L);
        enq_s       = gen_valid && (!full_s || deq_s);
        drop_s      = gen_valid && full_s && !deq_s;
        clear_s     = (state_r == S_FLUSH) && (outstanding_r == {LW{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush wins over start while running.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_RUN;
                else       state_next_s = S_IDLE;
            end
            S_RUN: begin
                if (flush) state_next_s = S_FLUSH;
                else       state_next_s = S_RUN;
            end
            S_FLUSH: begin
                if (clear_s) state_next_s = S_IDLE;
                else         state_next_s = S_FLUSH;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM outputs; requests are issued only when stored plus in-flight points still fit.
    always_comb begin
        busy    = (state_r != S_IDLE);
        gen_pop = (state_r == S_RUN) &&
                  (({1'b0, level_r} + {1'b0, outstanding_r}) < DEPTH_S);
    end

    // In-flight request counter; a stray return with nothing outstanding does not wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= {LW{1'b0}};
        end else begin
            case ({gen_pop, gen_valid})
                2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
                2'b01:   outstanding_r <= (outstanding_r != {LW{1'b0}}) ? outstanding_r - CNT_ONE
                                                                        : outstanding_r;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Occupancy after this cycle's enqueue/dequeue.
    always_comb begin
        case ({enq_s, deq_s})
            2'b10:   level_next_s = level_r + CNT_ONE;
            2'b01:   level_next_s = level_r - CNT_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Pointers, occupancy and sticky overflow; the flush clear overrides any same-edge traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (drop_s) overflow_r <= 1'b1;
            else        overflow_r <= overflow_r;
            if (clear_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                level_r  <= {LW{1'b0}};
            end else begin
                if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
                level_r <= level_next_s;
            end
        end
    end

    // Point storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_x_r[wr_ptr_r] <= gen_x;
            mem_y_r[wr_ptr_r] <= gen_y;
        end
    end

    // Head presentation, held at zero whenever no valid point is shown.
    always_comb begin
        out_valid = out_valid_s;
        level     = level_r;
        overflow  = overflow_r;
        if (out_valid_s) begin
            out_x = mem_x_r[rd_ptr_r];
            out_y = mem_y_r[rd_ptr_r];
        end else begin
            out_x = {WIDTH{1'b0}};
            out_y = {WIDTH{1'b0}};
        end
    end

`ifdef HALTON_PAIR_BUFFER_STATS_EN
    logic [31:0] pt_count_r;

    // Dequeued-point counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_count_r <= 32'd0;
        end else if (deq_s) begin
            pt_count_r <= pt_count_r + 32'd1;
        end else begin
            pt_count_r <= pt_count_r;
        end
    end

    assign pt_count = pt_count_r;
`else
`endif

endmodule

// File: tb/tb_halton_pair_buffer.sv
// Scoreboard bench for halton_pair_buffer: a Halton generator model with 1-cycle latency,
// a queue-based reference model, and a monitor that pops expected points on every dequeue.
module tb_halton_pair_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             flush;
    logic             gen_pop;
    logic [WIDTH-1:0] gen_x;
    logic [WIDTH-1:0] gen_y;
    logic             gen_valid;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             busy;
`ifdef HALTON_PAIR_BUFFER_STATS_EN
    logic [31:0]      pt_count;
`endif

    halton_pair_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .gen_pop(gen_pop), .gen_x(gen_x), .gen_y(gen_y), .gen_valid(gen_valid),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .busy(busy)
`ifdef HALTON_PAIR_BUFFER_STATS_EN
        , .pt_count(pt_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: operating mode, stored-point count, in-flight requests, sticky flag, dequeues.
    int          m_state;   // 0 idle, 1 run, 2 flush
    int          m_level;
    int          m_out;
    bit          m_ovf;
    longint      m_pt;
    logic [63:0] exp_q[$];
    bit          pending;
    bit          force_gv;
    int          gidx;
    int          pop_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] h2(input int i);
        logic [31:0] v;
        logic [31:0] r;
        v = i;
        for (int b = 0; b < 32; b++) r[31-b] = v[b];
        return r;
    endfunction

    function automatic logic [31:0] h3(input int i);
        real r;
        real f;
        int  n;
        r = 0.0;
        f = 1.0 / 3.0;
        n = i;
        while (n > 0) begin
            r = r + f * (n % 3);
            n = n / 3;
            f = f / 3.0;
        end
        return 32'(longint'($floor(r * 4294967296.0)));
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_out = 0; m_ovf = 1'b0; m_pt = 0;
        exp_q.delete();
        pending = 1'b0;
    endtask

    task automatic check_outputs();
        chk("level", level, m_level);
        chk("gen_pop", gen_pop, (m_state == 1 && m_level + m_out < DEPTH) ? 1 : 0);
        chk("out_valid", out_valid, (m_state != 2 && m_level != 0) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, (m_state != 0) ? 1 : 0);
`ifdef HALTON_PAIR_BUFFER_STATS_EN
        chk("pt_count", pt_count, m_pt & 64'hFFFF_FFFF);
`endif
    endtask

    task automatic model_step();
        bit pop, deq, enq, gv, clear;
        gv    = gen_valid;
        pop   = (m_state == 1) && (m_level + m_out < DEPTH);
        deq   = (m_state != 2) && (m_level != 0) && out_ready;
        enq   = gv && (m_level < DEPTH || deq);
        clear = (m_state == 2) && (m_out == 0);
        if (gv && !enq) m_ovf = 1'b1;
        if (enq) exp_q.push_back({gen_x, gen_y});
        if (deq) m_pt++;
        m_level = m_level + (enq ? 1 : 0) - (deq ? 1 : 0);
        if (pop && !gv) m_out++;
        else if (!pop && gv && m_out > 0) m_out--;
        case (m_state)
            0: if (start) m_state = 1;
            1: if (flush) m_state = 2;
            default: if (clear) begin
                m_state = 0;
                m_level = 0;
                exp_q.delete();
            end
        endcase
    endtask

    // One clock: check and advance the model at the falling edge, then drive the generator after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        pop_cnt += gen_pop ? 1 : 0;
        pending = gen_pop;
        @(posedge clk);
        #1;
        gen_valid = pending || force_gv;
        if (pending) begin
            gen_x = h2(gidx);
            gen_y = h3(gidx);
            gidx++;
        end else begin
            gen_x = (force_gv) ? 32'hDEAD_BEEF : $urandom;
            gen_y = (force_gv) ? 32'hCAFE_F00D : $urandom;
        end
    endtask

    task automatic flush_and_wait();
        int n;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            cycle();
            n++;
        end
        chk("flush_idle", busy, 0);
        chk("flush_level", level, 0);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen_pop", gen_pop, 0);
        chk("rst_out_x", out_x, 0);
        model_reset();
        gen_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head point must be the oldest expected one.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: dequeue of %0h/%0h with nothing expected", out_x, out_y);
            end else begin
                e = exp_q.pop_front();
                chk("out_x", out_x, e[63:32]);
                chk("out_y", out_y, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcnt;
        rst = 1'b1; start = 1'b0; flush = 1'b0; gen_valid = 1'b0; out_ready = 1'b0;
        gen_x = 32'd0; gen_y = 32'd0; force_gv = 1'b0; gidx = 1; pop_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_level", level, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_gen_pop", gen_pop, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_out_x", out_x, 0);
        chk("reset_out_y", out_y, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with the consumer always ready.
        out_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("first_x", out_x, 32'h8000_0000);
        chk("first_y", out_y, 32'h5555_5555);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            vcnt += out_valid ? 1 : 0;
        end
        chk("stream_rate", vcnt, 20);
        flush_and_wait();

        // Stalled consumer: credit must limit requests to DEPTH.
        out_ready = 1'b0;
        pop_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        chk("stall_pops", pop_cnt, DEPTH);
        chk("stall_level", level, DEPTH);
        chk("stall_gen_pop", gen_pop, 0);
        chk("stall_overflow", overflow, 0);

        // Forced return into a full FIFO is dropped.
        force_gv = 1'b1;
        cycle();
        force_gv = 1'b0;
        repeat (2) cycle();
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, DEPTH);
        chk("ovf_head_x", out_x, exp_q[0][63:32]);
        flush_and_wait();
        chk("ovf_sticky", overflow, 1);

        // Flush in the same cycle as the first request.
        out_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("pre_flush_pop", gen_pop, 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            cycle();
            n++;
        end
        chk("flush_pop_cycles", n, 2);
        chk("flush_pop_busy", busy, 0);
        chk("flush_pop_level", level, 0);

        // Randomised traffic with occasional start/flush/forced returns.
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            force_gv  = ($urandom_range(0, 60) == 0);
            cycle();
        end
        start = 1'b0; flush = 1'b0; force_gv = 1'b0;
        cycle();
        flush_and_wait();

        // Asynchronous reset mid-run with three points stored.
        out_ready = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (level != LW'(3) && n < 10) begin
            cycle();
            n++;
        end
        chk("pre_rst_level", level, 3);
        pulse_reset();
        pop_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (15) cycle();
        chk("restart_pops", pop_cnt, DEPTH);
        chk("restart_level", level, DEPTH);
        flush_and_wait();

`ifdef HALTON_PAIR_BUFFER_STATS_EN
        // Dequeue counter survives flush and clears on reset.
        pulse_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (m_pt < 10 && n < 60) begin
            out_ready = (m_pt < 10);
            cycle();
            n++;
        end
        out_ready = 1'b0;
        cycle();
        flush_and_wait();
        chk("stats_after_flush", pt_count, 10);
        pulse_reset();
        chk("stats_after_reset", pt_count, 0);
`endif

        repeat (3) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
